// File: rtl/ram_load_ctrl_if.sv
// Bundles the CPU load request, RAM read port and load response channels of ram_load_ctrl.
// No logic; a pure signal bundle.
// slave = the load controller, master = the CPU/RAM side driving requests and read data.
//
// Signals: req_valid/req_ready/req_addr/req_size/req_signed (request),
//          ram_re/ram_addr/ram_rdata (RAM read port),
//          rsp_valid/rsp_ready/rsp_data/rsp_err (response).
interface ram_load_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;

    logic              ram_re;
    logic [ADDR_W-3:0] ram_addr;
    logic [31:0]       ram_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_addr, req_size, req_signed, ram_rdata, rsp_ready,
        output req_ready, ram_re, ram_addr, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_size, req_signed, ram_rdata, rsp_ready,
        input  req_ready, ram_re, ram_addr, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ram_load_ctrl.sv
// Byte/word/long load controller: long-aligned RAM reads, byte shift, zero/sign extension.
// Latency accept->rsp_valid: 2+RAM_LATENCY (one read), 3+2*RAM_LATENCY (two reads), 1 (error).
// Backpressure: rsp held stable until rsp_ready; req_ready only in IDLE, one load in flight.
//
// Ports: clk, rst (synchronous, active-high), bus (ram_load_ctrl_if.slave) carrying the
//        request, RAM read and response channels.
// Optional feature macro RAM_LOAD_MISALIGN_EN: serve misaligned word/long loads, using a
// second read at index+1 when the access straddles two longs. Without it they return rsp_err.
module ram_load_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    ram_load_ctrl_if.slave bus
);
    localparam int         IW  = ADDR_W - 2;
    localparam logic [1:0] LAT = 2'(RAM_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        WAIT1,
        RD2,
        WAIT2,
        RESP
    } state_t;

    state_t          state;
    logic [1:0]      cnt;
    logic [1:0]      off;
    logic [1:0]      size;
    logic            sgn;
    logic [IW-1:0]   idx;
`ifdef RAM_LOAD_MISALIGN_EN
    logic [31:0]     lo;        // first long of a straddling access
`endif

    logic            ram_re_q;
    logic [IW-1:0]   ram_addr_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_data_q;
    logic            rsp_err_q;
    logic            req_err;

    // Shift the (up to 64-bit) little-endian window down to the addressed byte, then
    // mask and extend to the requested size. Long loads ignore the signed flag.
    function automatic logic [31:0] extract(input logic [63:0] d, input logic [1:0] o,
                                            input logic [1:0] sz, input logic sg);
        logic [31:0] s;
        s = 32'(d >> {o, 3'b000});
        case (sz)
            2'b00:   extract = {{24{sg & s[7]}}, s[7:0]};
            2'b01:   extract = {{16{sg & s[15]}}, s[15:0]};
            default: extract = s;
        endcase
    endfunction

`ifdef RAM_LOAD_MISALIGN_EN
    // True when offset + access bytes runs past the end of the first long.
    function automatic logic two_reads(input logic [1:0] o, input logic [1:0] sz);
        two_reads = ((sz == 2'b01) && (o == 2'b11)) || ((sz == 2'b10) && (o != 2'b00));
    endfunction
`else
    function automatic logic misaligned(input logic [1:0] o, input logic [1:0] sz);
        misaligned = ((sz == 2'b01) && o[0]) || ((sz == 2'b10) && (o != 2'b00));
    endfunction
`endif

    always_comb begin
        req_err = (bus.req_size == 2'b11);
`ifndef RAM_LOAD_MISALIGN_EN
        if (misaligned(bus.req_addr[1:0], bus.req_size)) begin
            req_err = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            off         <= 2'd0;
            size        <= 2'd0;
            sgn         <= 1'b0;
            idx         <= '0;
`ifdef RAM_LOAD_MISALIGN_EN
            lo          <= 32'd0;
`endif
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        off  <= bus.req_addr[1:0];
                        size <= bus.req_size;
                        sgn  <= bus.req_signed;
                        idx  <= bus.req_addr[ADDR_W-1:2];
                        if (req_err) begin
                            // Rejected loads answer next cycle without touching RAM.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= 32'd0;
                            state       <= RESP;
                        end else begin
                            ram_re_q   <= 1'b1;
                            ram_addr_q <= bus.req_addr[ADDR_W-1:2];
                            state      <= RD1;
                        end
                    end
                end
                RD1: begin
                    ram_re_q <= 1'b0;
                    cnt      <= 2'd1;
                    state    <= WAIT1;
                end
                WAIT1: begin
                    // cnt==LAT marks the cycle ram_rdata belongs to the strobe.
                    if (cnt == LAT) begin
`ifdef RAM_LOAD_MISALIGN_EN
                        if (two_reads(off, size)) begin
                            lo         <= bus.ram_rdata;
                            ram_re_q   <= 1'b1;
                            ram_addr_q <= idx + IW'(1);   // wraps at the top of RAM
                            state      <= RD2;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= extract({32'd0, bus.ram_rdata}, off, size, sgn);
                            state       <= RESP;
                        end
`else
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= extract({32'd0, bus.ram_rdata}, off, size, sgn);
                        state       <= RESP;
`endif
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
`ifdef RAM_LOAD_MISALIGN_EN
                RD2: begin
                    ram_re_q <= 1'b0;
                    cnt      <= 2'd1;
                    state    <= WAIT2;
                end
                WAIT2: begin
                    if (cnt == LAT) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= extract({bus.ram_rdata, lo}, off, size, sgn);
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
`endif
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst so no request is taken while reset is held.
    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.ram_re    = ram_re_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_ram_load_ctrl.sv
// Self-checking bench for ram_load_ctrl: directed cases plus random loads against a
// byte-level memory model; a negedge monitor pops the expected-response queue.
module tb_ram_load_ctrl;
    localparam int ADDR_W = 16;
    localparam int LAT    = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   nrsp   = 0;
    bit   hold_low = 0;

    ram_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ram_load_ctrl #(.ADDR_W(ADDR_W), .RAM_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data appears LAT cycles after the strobe, junk otherwise.
    logic [31:0] mem [0:(1<<(ADDR_W-2))-1];
    logic [31:0] rd_pipe [0:2];
    always @(posedge clk) begin
        rd_pipe[0] <= bus.ram_re ? mem[bus.ram_addr] : $urandom;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign bus.ram_rdata = rd_pipe[LAT-1];

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          nrd;
        logic [13:0] i0;
        logic [13:0] i1;
        int          acc;
    } exp_t;

    exp_t        exp_q [$];
    logic [13:0] rd_log [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        fails++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference: assemble the load byte by byte from memory, then extend.
    function automatic exp_t model(input logic [15:0] a, input logic [1:0] sz, input logic sg);
        exp_t        e;
        int          nb;
        logic [31:0] v;
        logic [31:0] w;
        logic [15:0] ba;
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.err = (sz == 2'd3);
`ifndef RAM_LOAD_MISALIGN_EN
        if ((int'(a) % nb) != 0) e.err = 1'b1;
`endif
        e.i0  = a[15:2];
        e.i1  = a[15:2] + 14'd1;
        e.acc = 0;
        if (e.err) begin
            e.data = 32'd0;
            e.nrd  = 0;
            e.lat  = 1;
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) begin
                ba = a + 16'(i);
                w  = mem[ba[15:2]] >> (8 * int'(ba[1:0]));
                v[8*i +: 8] = w[7:0];
            end
            if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            e.data = v;
            e.nrd  = ((int'(a[1:0]) + nb) > 4) ? 2 : 1;
            e.lat  = (e.nrd == 1) ? 2 + LAT : 3 + 2 * LAT;
        end
        return e;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [1:0] sz, input logic sg, input bit push);
        exp_t e;
        bit   done;
        done = 0;
        e    = model(a, sz, sg);
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.req_size   = sz;
        bus.req_signed = sg;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                done  = 1;
                e.acc = cyc;
                if (push) exp_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        bus.req_valid  = 1'b0;
        bus.req_addr   = 16'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        if (!done) fail_now("accept_timeout");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready && exp_q.size() == 0) ok = 1;
        end
        if (!ok) fail_now("idle_timeout");
    endtask

    // Consumer readiness: random, or held low for the backpressure case.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    bit          pv  = 0;
    bit          phs = 0;
    logic [31:0] pd;
    logic        pe;
    exp_t        me;
    always @(negedge clk) begin
        if (rst) begin
            rd_log.delete();
            pv  = 0;
            phs = 0;
        end else begin
            if (bus.ram_re) rd_log.push_back(bus.ram_addr);
            if (bus.rsp_valid) begin
                chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
                if (pv && !phs) begin
                    chk("hold_data", bus.rsp_data, pd);
                    chk("hold_err", 32'(bus.rsp_err), 32'(pe));
                end else if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                end
                if (bus.rsp_ready) begin
                    nrsp++;
                    if (exp_q.size() != 0) begin
                        me = exp_q.pop_front();
                        chk("rsp_data", bus.rsp_data, me.data);
                        chk("rsp_err", 32'(bus.rsp_err), 32'(me.err));
                        chk("rd_count", 32'(rd_log.size()), 32'(me.nrd));
                        if (rd_log.size() == me.nrd && me.nrd >= 1) chk("rd_idx0", 32'(rd_log[0]), 32'(me.i0));
                        if (rd_log.size() == me.nrd && me.nrd == 2) chk("rd_idx1", 32'(rd_log[1]), 32'(me.i1));
                    end
                    rd_log.delete();
                end
            end
            pv  = bus.rsp_valid;
            phs = bus.rsp_valid && bus.rsp_ready;
            pd  = bus.rsp_data;
            pe  = bus.rsp_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    int          n0;
    bit          seen;
    logic [15:0] ra;
    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = 16'd0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        for (int i = 0; i < (1 << (ADDR_W - 2)); i++) mem[i] = $urandom;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_ram_re", 32'(bus.ram_re), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Aligned signed byte, then word at offset 2 unsigned and signed.
        wait_idle();
        mem[14'h040] = 32'h1280_7F00;
        issue(16'h0102, 2'd0, 1'b1, 1);
        wait_idle();
        mem[14'h040] = 32'hBEEF_1234;
        issue(16'h0102, 2'd1, 1'b0, 1);
        issue(16'h0102, 2'd1, 1'b1, 1);

        // Backpressure: consumer stalls five cycles, exactly one response.
        wait_idle();
        n0 = nrsp;
        hold_low = 1;
        issue(16'h0040, 2'd2, 1'b0, 1);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        if (!seen) fail_now("bp_rsp_timeout");
        repeat (5) @(negedge clk);
        hold_low = 0;
        wait_idle();
        chk("bp_one_response", 32'(nrsp - n0), 32'd1);

        // Misaligned long straddling index 0/1, then wrapping word at the top of RAM.
        wait_idle();
        mem[14'h0000] = 32'hAABB_CCDD;
        mem[14'h0001] = 32'h1122_3344;
        issue(16'h0003, 2'd2, 1'b0, 1);
        issue(16'hFFFF, 2'd1, 1'b0, 1);
        issue(16'hFFFF, 2'd1, 1'b1, 1);
        issue(16'h0000, 2'd3, 1'b1, 1);

        // Reset while waiting for RAM data: no response, then normal operation.
        wait_idle();
        n0 = nrsp;
        issue(16'h0102, 2'd0, 1'b1, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_idle", 32'(bus.req_ready), 32'd1);
        chk("abort_ram_re", 32'(bus.ram_re), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_no_rsp", 32'(nrsp - n0), 32'd0);
        issue(16'h0102, 2'd0, 1'b1, 1);

        // Random loads, biased towards the top of the address space.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFC | 16'($urandom_range(0, 3));
            else ra = 16'($urandom);
            issue(ra, 2'($urandom), 1'($urandom), 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        wait_idle();
        repeat (10) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
